// File: rtl/continuous_monitoring_system_pkg.sv
// continuous_monitoring_system_pkg: trace record layout, widths and field offsets shared by the trace path
package continuous_monitoring_system_pkg;
  localparam int RISC_V_INSTRUCTION_WIDTH = 32;
  localparam int TRACE_RECORD_WIDTH = 128;
  localparam int REC_SKIP_WIDTH = 16;
  localparam int PC_LSB = 0;
  localparam int INSTR_LSB = 64;
  localparam int SKIP_LSB = 96;
  localparam int LOST_BIT = 112;
  typedef struct packed {
    logic [14:0] pad;
    logic lost;
    logic [REC_SKIP_WIDTH-1:0] skip_cnt;
    logic [RISC_V_INSTRUCTION_WIDTH-1:0] instr;
    logic [63:0] pc;
  } trace_record_t;
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: sync FWFT fifo (clk, rst, wr_en/wr_data, rd_en/rd_data, full, empty, level); storage not reset
module trace_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic wr, rd;
  assign full = count == LW'(DEPTH);
  assign empty = count == '0;
  assign level = count;
  assign wr = wr_en && !full;
  assign rd = rd_en && !empty;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= rd ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + LW'(wr) - LW'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/trace_packer.sv
// trace_packer: packs kept trace items {lost,skip,instr,pc} into a fwft fifo (en/pc_valid/pc/instr/drop_instr in, m_data/m_valid/m_ready out, fifo_level, lost_count)
module trace_packer
  import continuous_monitoring_system_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int SKIP_CNT_WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic                                pc_valid,
  input  logic [63:0]                         pc,
  input  logic [RISC_V_INSTRUCTION_WIDTH-1:0] instr,
  input  logic                                drop_instr,
  output logic [TRACE_RECORD_WIDTH-1:0]       m_data,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
  output logic [31:0]                         lost_count
);
  logic [SKIP_CNT_WIDTH-1:0] skip_cnt;
  logic lost_flag, qual, full, empty, push;
  trace_record_t rec;
  assign qual = en && pc_valid;
  assign push = qual && !drop_instr && !full;
  assign m_valid = !empty;
  always_comb begin
    rec = '0;
    rec[PC_LSB +: 64] = pc;
    rec[INSTR_LSB +: RISC_V_INSTRUCTION_WIDTH] = instr;
    rec[SKIP_LSB +: REC_SKIP_WIDTH] = REC_SKIP_WIDTH'(skip_cnt);
    rec[LOST_BIT] = lost_flag;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      skip_cnt <= '0;
      lost_flag <= 1'b0;
      lost_count <= '0;
    end else if (qual) begin
      skip_cnt <= push ? '0 : &skip_cnt ? skip_cnt : skip_cnt + SKIP_CNT_WIDTH'(1);
      lost_flag <= push ? 1'b0 : drop_instr ? lost_flag : 1'b1;
      if (!drop_instr && full) lost_count <= &lost_count ? lost_count : lost_count + 32'd1;
    end
  trace_fifo #(.WIDTH(TRACE_RECORD_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(push),
    .wr_data(rec),
    .rd_en(m_ready),
    .rd_data(m_data),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
endmodule

// File: tb/tb_trace_packer.sv
// tb_trace_packer: directed table plus corner sequences for trace_packer
module tb_trace_packer;
  logic clk = 0, rst = 1, en = 0, pc_valid = 0, drop_instr = 0, m_ready = 0;
  logic [63:0] pc = '0;
  logic [31:0] instr = '0;
  logic [127:0] m_data;
  logic m_valid;
  logic [4:0] fifo_level;
  logic [31:0] lost_count;
  int checks = 0, errors = 0;

  trace_packer #(.FIFO_DEPTH(16), .SKIP_CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .en(en), .pc_valid(pc_valid), .pc(pc), .instr(instr),
    .drop_instr(drop_instr), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_level(fifo_level), .lost_count(lost_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic e, pv, dr, rdy;
    logic [63:0] p;
    logic [31:0] ins;
    int lvl;
    logic vld;
    logic chk;
    logic [127:0] dat;
    logic [31:0] lost;
  } vec_t;
  vec_t v[8];

  function automatic logic [127:0] rec(logic l, logic [15:0] s, logic [31:0] i, logic [63:0] p);
    return {15'b0, l, s, i, p};
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc(logic e, logic pv, logic dr, logic [63:0] p, logic [31:0] i, logic rdy);
    en = e; pc_valid = pv; drop_instr = dr; pc = p; instr = i; m_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 0; pc_valid = 0; drop_instr = 0; m_ready = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    v[0] = '{1, 1, 1, 0, 64'h0, 32'h0, 0, 0, 0, '0, 0};
    v[1] = '{1, 1, 1, 0, 64'h4, 32'h0, 0, 0, 0, '0, 0};
    v[2] = '{1, 1, 1, 0, 64'h8, 32'h0, 0, 0, 0, '0, 0};
    v[3] = '{1, 1, 0, 0, 64'h80000010, 32'h00008067, 1, 1, 1, rec(0, 3, 32'h00008067, 64'h80000010), 0};
    v[4] = '{0, 1, 0, 0, 64'h11, 32'h22, 1, 1, 1, rec(0, 3, 32'h00008067, 64'h80000010), 0};
    v[5] = '{1, 0, 0, 0, 64'h33, 32'h44, 1, 1, 1, rec(0, 3, 32'h00008067, 64'h80000010), 0};
    v[6] = '{1, 1, 0, 1, 64'h100, 32'h13, 1, 1, 1, rec(0, 0, 32'h13, 64'h100), 0};
    v[7] = '{0, 0, 0, 1, 64'h0, 32'h0, 0, 0, 0, '0, 0};

    do_reset();
    chk("reset_valid", 128'(m_valid), 0);
    chk("reset_level", 128'(fifo_level), 0);
    chk("reset_lost", 128'(lost_count), 0);

    for (int k = 0; k < 8; k++) begin
      cyc(v[k].e, v[k].pv, v[k].dr, v[k].p, v[k].ins, v[k].rdy);
      chk($sformatf("vec%0d_level", k), 128'(fifo_level), 128'(v[k].lvl));
      chk($sformatf("vec%0d_valid", k), 128'(m_valid), 128'(v[k].vld));
      chk($sformatf("vec%0d_lost", k), 128'(lost_count), 128'(v[k].lost));
      if (v[k].chk) chk($sformatf("vec%0d_data", k), m_data, v[k].dat);
    end

    // overflow: 18 kept with no drain, then one pop, then a kept item carrying skip=2 lost=1
    do_reset();
    for (int k = 0; k < 18; k++) cyc(1, 1, 0, 64'(k), 32'(k + 'h1000), 0);
    chk("ovf_level", 128'(fifo_level), 16);
    chk("ovf_lost", 128'(lost_count), 2);
    chk("ovf_head", m_data, rec(0, 0, 32'h1000, 64'h0));
    cyc(0, 0, 0, 0, 0, 1);
    chk("ovf_pop_level", 128'(fifo_level), 15);
    cyc(1, 1, 0, 64'hAA, 32'hBB, 0);
    chk("ovf_refill_level", 128'(fifo_level), 16);
    chk("ovf_refill_lost", 128'(lost_count), 2);
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("drain%0d", k), m_data,
          k < 16 ? rec(0, 0, 32'(k + 'h1000), 64'(k)) : rec(1, 2, 32'hBB, 64'hAA));
      cyc(0, 0, 0, 0, 0, 1);
    end
    chk("drain_valid", 128'(m_valid), 0);
    chk("drain_level", 128'(fifo_level), 0);

    // skip counter saturation
    do_reset();
    cyc(1, 1, 1, 0, 0, 0);
    en = 1; pc_valid = 1; drop_instr = 1;
    repeat (65536 + 4) @(posedge clk);
    #1;
    cyc(1, 1, 0, 64'h1234, 32'h5678, 0);
    chk("sat_data", m_data, rec(0, 16'hFFFF, 32'h5678, 64'h1234));

    // en=0 ignores items and leaves skip count alone
    do_reset();
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    for (int k = 0; k < 10; k++) cyc(0, 1, k[0], 64'(k), 32'(k), 0);
    chk("en0_level", 128'(fifo_level), 0);
    chk("en0_valid", 128'(m_valid), 0);
    cyc(1, 1, 0, 64'h77, 32'h88, 0);
    chk("en0_data", m_data, rec(0, 2, 32'h88, 64'h77));

    // full fifo: simultaneous pop and kept push is rejected
    do_reset();
    for (int k = 0; k < 16; k++) cyc(1, 1, 0, 64'(k), 32'(k + 'h1000), 0);
    chk("full_level", 128'(fifo_level), 16);
    cyc(1, 1, 0, 64'h99, 32'h99, 1);
    chk("fullpp_level", 128'(fifo_level), 15);
    chk("fullpp_lost", 128'(lost_count), 1);
    chk("fullpp_head", m_data, rec(0, 0, 32'h1001, 64'h1));

    // asynchronous reset while a record is stalled
    en = 0; pc_valid = 0; m_ready = 0;
    #2;
    rst = 1;
    #1;
    chk("arst_valid", 128'(m_valid), 0);
    chk("arst_level", 128'(fifo_level), 0);
    chk("arst_lost", 128'(lost_count), 0);
    @(negedge clk);
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
